// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus and register-bank write command bus seen by regfile_write_arbiter.
// The slave modport is the arbiter; the master modport is the requester/bank side.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 64
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*AW-1:0]     req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [1:0]                wr_en;
  logic [2*AW-1:0]           wr_addr;
  logic [2*DATA_W-1:0]       wr_data;
  logic [NUM_REGS-1:0]       reg_en;
  logic                      soft_reset;

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data, reg_en, soft_reset
  );

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data, reg_en, soft_reset
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the two register-file write ports among NUM_REQ writeback requesters.
// Define REGFILE_ARB_PERF_EN to add the saturating perf_grants/perf_conflicts counters.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  regfile_write_arbiter_if.slave wb
`ifdef REGFILE_ARB_PERF_EN
  ,
  output logic [31:0] perf_grants,
  output logic [31:0] perf_conflicts
`endif
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return IW'(s % NUM_REQ);
  endfunction

`ifdef REGFILE_ARB_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
`endif

  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       rr_nxt;
  logic [IW-1:0]       scan_idx;
  logic [AW-1:0]       scan_addr;
  logic                g0_vld_p0, g1_vld_p0, conflict_p0;
  logic [IW-1:0]       g0_idx_p0, g1_idx_p0;
  logic [AW-1:0]       g0_addr_p0, g1_addr_p0;
  logic [DATA_W-1:0]   g0_data_p0, g1_data_p0;
  logic [NUM_REQ-1:0]  ready_p0;

  logic [1:0]          en_nxt;
  logic [AW-1:0]       addr_nxt [2];
  logic [DATA_W-1:0]   data_nxt [2];
  logic [NUM_REGS-1:0] reg_en_nxt;

  logic [1:0]          vld_p1;
  logic [AW-1:0]       wr_addr_p1 [2];
  logic [DATA_W-1:0]   wr_data_p1 [2];
  logic [NUM_REGS-1:0] reg_en_p1;
  logic                soft_reset_p1;

  // Stage p0: grant selection. The second grant skips requesters that collide with the
  // first grant's nonzero address; those stay pending for a later cycle.
  always_comb begin
    g0_vld_p0   = 1'b0;
    g1_vld_p0   = 1'b0;
    conflict_p0 = 1'b0;
    g0_idx_p0   = '0;
    g1_idx_p0   = '0;
    g0_addr_p0  = '0;
    g1_addr_p0  = '0;
    scan_idx    = '0;
    scan_addr   = '0;
    ready_p0    = '0;
    if (reset && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx  = wrap_idx(rr_ptr, k);
        scan_addr = wb.req_addr[int'(scan_idx)*AW +: AW];
        if (wb.req_valid[scan_idx]) begin
          if (!g0_vld_p0) begin
            g0_vld_p0  = 1'b1;
            g0_idx_p0  = scan_idx;
            g0_addr_p0 = scan_addr;
          end else if (!g1_vld_p0) begin
            if (scan_addr != '0 && scan_addr == g0_addr_p0) begin
              conflict_p0 = 1'b1;
            end else begin
              g1_vld_p0  = 1'b1;
              g1_idx_p0  = scan_idx;
              g1_addr_p0 = scan_addr;
            end
          end
        end
      end
      if (g0_vld_p0) ready_p0[g0_idx_p0] = 1'b1;
      if (g1_vld_p0) ready_p0[g1_idx_p0] = 1'b1;
    end
  end

  assign wb.req_ready = ready_p0;
  assign g0_data_p0   = wb.req_data[int'(g0_idx_p0)*DATA_W +: DATA_W];
  assign g1_data_p0   = wb.req_data[int'(g1_idx_p0)*DATA_W +: DATA_W];

  always_comb begin
    en_nxt      = '0;
    addr_nxt[0] = '0;
    addr_nxt[1] = '0;
    data_nxt[0] = '0;
    data_nxt[1] = '0;
    if (g0_vld_p0 && g0_addr_p0 != '0) begin
      en_nxt[0]   = 1'b1;
      addr_nxt[0] = g0_addr_p0;
      data_nxt[0] = g0_data_p0;
    end
    if (g1_vld_p0 && g1_addr_p0 != '0) begin
      en_nxt[1]   = 1'b1;
      addr_nxt[1] = g1_addr_p0;
      data_nxt[1] = g1_data_p0;
    end
    reg_en_nxt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      reg_en_nxt[r] = (en_nxt[0] && addr_nxt[0] == AW'(r)) ||
                      (en_nxt[1] && addr_nxt[1] == AW'(r));
    end
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (g1_vld_p0)      rr_nxt = wrap_idx(g1_idx_p0, 1);
    else if (g0_vld_p0) rr_nxt = wrap_idx(g0_idx_p0, 1);
  end

  // Stage p1: registered write commands, held for exactly one cycle. A flush cycle has no
  // grants, so the command registers clear through the normal next-value path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr        <= '0;
      vld_p1        <= '0;
      wr_addr_p1[0] <= '0;
      wr_addr_p1[1] <= '0;
      wr_data_p1[0] <= '0;
      wr_data_p1[1] <= '0;
      reg_en_p1     <= '0;
      soft_reset_p1 <= 1'b0;
    end else begin
      rr_ptr        <= flush ? '0 : rr_nxt;
      soft_reset_p1 <= flush;
      vld_p1        <= en_nxt;
      wr_addr_p1[0] <= addr_nxt[0];
      wr_addr_p1[1] <= addr_nxt[1];
      wr_data_p1[0] <= data_nxt[0];
      wr_data_p1[1] <= data_nxt[1];
      reg_en_p1     <= reg_en_nxt;
    end
  end

  assign wb.wr_en      = vld_p1;
  assign wb.wr_addr    = {wr_addr_p1[1], wr_addr_p1[0]};
  assign wb.wr_data    = {wr_data_p1[1], wr_data_p1[0]};
  assign wb.reg_en     = reg_en_p1;
  assign wb.soft_reset = soft_reset_p1;

`ifdef REGFILE_ARB_PERF_EN
  logic [31:0] grants_p1, conflicts_p1;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grants_p1    <= '0;
      conflicts_p1 <= '0;
    end else begin
      grants_p1    <= sat_add(grants_p1, 32'(g0_vld_p0) + 32'(g1_vld_p0));
      conflicts_p1 <= sat_add(conflicts_p1, 32'(conflict_p0));
    end
  end

  assign perf_grants    = grants_p1;
  assign perf_conflicts = conflicts_p1;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vectors with literal expectations plus a
// behavioural scan-order model compared against the DUT on every cycle.
module tb_regfile_write_arbiter;
  localparam int N  = 4;
  localparam int R  = 32;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  regfile_write_arbiter_if #(.NUM_REQ(N), .NUM_REGS(R), .DATA_W(DW)) bus ();

`ifdef REGFILE_ARB_PERF_EN
  logic [31:0] perf_grants, perf_conflicts;
`endif

  regfile_write_arbiter #(.NUM_REQ(N), .NUM_REGS(R), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .wb    (bus)
`ifdef REGFILE_ARB_PERF_EN
    ,
    .perf_grants    (perf_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: list valid requesters in rotation order starting at the pointer,
  // take the first, then the first later one whose address does not collide.
  typedef struct packed {
    logic       g0v;
    logic       g1v;
    logic       conf;
    logic [1:0] g0;
    logic [1:0] g1;
  } pick_t;

  function automatic pick_t pick(input int rr, input logic [N-1:0] v,
                                 input logic [N*AW-1:0] addrs, input logic fl, input logic rs);
    pick_t p;
    int order[$];
    logic [AW-1:0] a0, ai;
    p = '0;
    if (!rs || fl) return p;
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) order.push_back((rr + k) % N);
    if (order.size() == 0) return p;
    p.g0v = 1'b1;
    p.g0  = 2'(order[0]);
    a0    = addrs[order[0]*AW +: AW];
    for (int j = 1; j < order.size(); j++) begin
      ai = addrs[order[j]*AW +: AW];
      if (ai != 0 && ai == a0) begin
        p.conf = 1'b1;
      end else begin
        p.g1v = 1'b1;
        p.g1  = 2'(order[j]);
        break;
      end
    end
    return p;
  endfunction

  int            m_rr;
  pick_t         cur;
  logic [N-1:0]  exp_ready;
  logic [AW-1:0] pa0, pa1;
  logic [DW-1:0] pd0, pd1;

  always_comb begin
    cur       = pick(m_rr, bus.req_valid, bus.req_addr, flush, reset);
    exp_ready = '0;
    if (cur.g0v) exp_ready[cur.g0] = 1'b1;
    if (cur.g1v) exp_ready[cur.g1] = 1'b1;
  end

  assign pa0 = cur.g0v ? bus.req_addr[cur.g0*AW +: AW] : '0;
  assign pa1 = cur.g1v ? bus.req_addr[cur.g1*AW +: AW] : '0;
  assign pd0 = (pa0 != 0) ? bus.req_data[cur.g0*DW +: DW] : '0;
  assign pd1 = (pa1 != 0) ? bus.req_data[cur.g1*DW +: DW] : '0;

  logic [1:0]    e_en, e_dchk;
  logic [AW-1:0] e_addr0, e_addr1;
  logic [DW-1:0] e_data0, e_data1;
  logic [R-1:0]  e_regen;
  logic          e_soft;
  logic [32:0]   e_grants, e_conf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rr     <= 0;
      e_en     <= '0;
      e_dchk   <= 2'b11;
      e_addr0  <= '0;
      e_addr1  <= '0;
      e_data0  <= '0;
      e_data1  <= '0;
      e_regen  <= '0;
      e_soft   <= 1'b0;
      e_grants <= '0;
      e_conf   <= '0;
    end else begin
      e_soft  <= flush;
      e_en    <= {pa1 != 0, pa0 != 0};
      e_dchk  <= {!(cur.g1v && pa1 == 0), !(cur.g0v && pa0 == 0)};
      e_addr0 <= pa0;
      e_addr1 <= pa1;
      e_data0 <= pd0;
      e_data1 <= pd1;
      e_regen <= ((pa0 != 0) ? (R'(1) << pa0) : '0) | ((pa1 != 0) ? (R'(1) << pa1) : '0);
      if (flush)         m_rr <= 0;
      else if (cur.g1v)  m_rr <= (int'(cur.g1) + 1) % N;
      else if (cur.g0v)  m_rr <= (int'(cur.g0) + 1) % N;
      e_grants <= (e_grants + 33'(cur.g0v) + 33'(cur.g1v) > 33'hFFFF_FFFF) ? 33'hFFFF_FFFF
                : e_grants + 33'(cur.g0v) + 33'(cur.g1v);
      e_conf   <= (e_conf + 33'(cur.conf) > 33'hFFFF_FFFF) ? 33'hFFFF_FFFF
                : e_conf + 33'(cur.conf);
    end
  end

  always @(negedge clk) begin
    check("m_req_ready", 128'(bus.req_ready), 128'(exp_ready));
    check("m_wr_en", 128'(bus.wr_en), 128'(e_en));
    check("m_wr_addr0", 128'(bus.wr_addr[AW-1:0]), 128'(e_addr0));
    check("m_wr_addr1", 128'(bus.wr_addr[2*AW-1:AW]), 128'(e_addr1));
    if (e_dchk[0]) check("m_wr_data0", 128'(bus.wr_data[DW-1:0]), 128'(e_data0));
    if (e_dchk[1]) check("m_wr_data1", 128'(bus.wr_data[2*DW-1:DW]), 128'(e_data1));
    check("m_reg_en", 128'(bus.reg_en), 128'(e_regen));
    check("m_soft_reset", 128'(bus.soft_reset), 128'(e_soft));
`ifdef REGFILE_ARB_PERF_EN
    check("m_perf_grants", 128'(perf_grants), 128'(e_grants[31:0]));
    check("m_perf_conflicts", 128'(perf_conflicts), 128'(e_conf[31:0]));
`endif
  end

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]          = v;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_data[i*DW +: DW]  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(64'h1000 + i));
    #1;
    check("rst_ready", 128'(bus.req_ready), 128'(4'h0));
    check("rst_wr_en", 128'(bus.wr_en), 128'(2'b00));
    check("rst_reg_en", 128'(bus.reg_en), 128'(32'h0));
    check("rst_soft", 128'(bus.soft_reset), 128'(1'b0));
    step();
    step();
    reset = 1'b1;
    #1;
    check("rr_ready_a", 128'(bus.req_ready), 128'(4'b0011));
    step();
    check("rr_wr_en_a", 128'(bus.wr_en), 128'(2'b11));
    check("rr_wr_addr_a", 128'(bus.wr_addr), 128'({5'd2, 5'd1}));
    check("rr_wr_data0_a", 128'(bus.wr_data[DW-1:0]), 128'(64'h1000));
    check("rr_reg_en_a", 128'(bus.reg_en), 128'(32'h6));
    check("rr_ready_b", 128'(bus.req_ready), 128'(4'b1100));
    step();
    check("rr_wr_addr_b", 128'(bus.wr_addr), 128'({5'd4, 5'd3}));
    check("rr_reg_en_b", 128'(bus.reg_en), 128'(32'h18));
    check("rr_ready_c", 128'(bus.req_ready), 128'(4'b0011));
    step();
    check("rr_wr_addr_c", 128'(bus.wr_addr), 128'({5'd2, 5'd1}));

    flush = 1'b1;
    #1;
    check("fl_ready", 128'(bus.req_ready), 128'(4'h0));
    step();
    check("fl_wr_en", 128'(bus.wr_en), 128'(2'b00));
    check("fl_reg_en", 128'(bus.reg_en), 128'(32'h0));
    check("fl_soft", 128'(bus.soft_reset), 128'(1'b1));

    flush = 1'b0;
    set_req(0, 1'b1, 5'd5, 64'hA0);
    set_req(1, 1'b1, 5'd5, 64'hA1);
    set_req(2, 1'b1, 5'd6, 64'hA2);
    set_req(3, 1'b0, 5'd0, 64'h0);
    #1;
    check("cf_ready", 128'(bus.req_ready), 128'(4'b0101));
    step();
    check("cf_soft_fall", 128'(bus.soft_reset), 128'(1'b0));
    check("cf_reg_en", 128'(bus.reg_en), 128'(32'h60));
    check("cf_wr_addr", 128'(bus.wr_addr), 128'({5'd6, 5'd5}));
    check("cf_wr_data1", 128'(bus.wr_data[2*DW-1:DW]), 128'(64'hA2));
    set_req(0, 1'b0, 5'd5, 64'hA0);
    set_req(2, 1'b0, 5'd6, 64'hA2);
    #1;
    check("cf_retry_ready", 128'(bus.req_ready), 128'(4'b0010));
    step();
    check("cf_retry_en", 128'(bus.wr_en), 128'(2'b01));
    check("cf_retry_reg_en", 128'(bus.reg_en), 128'(32'h20));

    set_req(1, 1'b0, 5'd5, 64'hA1);
    set_req(3, 1'b1, 5'd0, 64'hDEAD);
    #1;
    check("az_ready", 128'(bus.req_ready), 128'(4'b1000));
    step();
    check("az_wr_en", 128'(bus.wr_en), 128'(2'b00));
    check("az_reg_en", 128'(bus.reg_en), 128'(32'h0));
    set_req(3, 1'b0, 5'd0, 64'h0);

    flush = 1'b1;
    step();
    check("sfl_soft_1", 128'(bus.soft_reset), 128'(1'b1));
    step();
    check("sfl_soft_2", 128'(bus.soft_reset), 128'(1'b1));
    flush = 1'b0;
    step();
    check("sfl_soft_3", 128'(bus.soft_reset), 128'(1'b0));

    set_req(0, 1'b1, 5'd7, 64'h77);
    step();
    check("mr_wr_en", 128'(bus.wr_en), 128'(2'b01));
    set_req(0, 1'b0, 5'd7, 64'h77);
    #2;
    reset = 1'b0;
    #1;
    check("mr_wr_en_drop", 128'(bus.wr_en), 128'(2'b00));
    check("mr_reg_en_drop", 128'(bus.reg_en), 128'(32'h0));
    step();
    reset = 1'b1;

    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), {$urandom, $urandom});
      flush = ($urandom_range(0, 9) == 0);
      step();
    end
    flush = 1'b0;
    bus.req_valid = '0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
